// File: rtl/phase_sync_ctrl.sv
// Synchronous consumer for the dual-rail PH0/PH1/PH2 tokens of the asynchronous phase ring.
// It resynchronises the rails, filters them for stability, decodes each token and returns a four-phase ack.
module phase_sync_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ph0,
    input  logic [1:0]       ph1,
    input  logic [1:0]       ph2,
    input  logic             clear_err,
    output logic             ack,
    output logic [2:0]       phase_word,
    output logic             word_valid,
    output logic             busy,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] token_cnt
);

    localparam int SCW = $clog2(STABLE_CYC + 1);
    localparam int TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_NULL,
        S_ERR
    } state_t;

    state_t r_state, w_state_next;

    logic [5:0]       w_rails_in;
    logic [5:0]       w_sync;
    logic [5:0]       r_prev_sync;
    logic [SCW-1:0]   r_stab_cnt;
    logic [TOW-1:0]   r_to_cnt;
    logic [2:0]       r_phase_word;
    logic [CNT_W-1:0] r_token_cnt;
    logic             r_err_illegal;
    logic             r_err_timeout;

    logic [2:0] w_is_null;
    logic [2:0] w_is_data;
    logic [2:0] w_is_illegal;
    logic [2:0] w_word;
    logic       w_same;
    logic       w_stable;
    logic       w_acc_data;
    logic       w_acc_null;
    logic       w_acc_illegal;
    logic       w_to_inc;
    logic       w_to_hit;
    logic       w_capture;
    logic       w_set_illegal;
    logic       w_set_timeout;

    assign w_rails_in = {ph2, ph1, ph0};

    // One independent synchronizer chain per rail; rails are only combined after this point.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_rails_in[gi]};
                end
            end
            assign w_sync[gi] = r_chain[SYNC_STAGES-1];
        end

        for (gi = 0; gi < 3; gi++) begin : g_decode
            assign w_is_null[gi]    = (w_sync[2*gi+1 -: 2] == 2'b00);
            assign w_is_illegal[gi] = (w_sync[2*gi+1 -: 2] == 2'b11);
            assign w_is_data[gi]    = ^w_sync[2*gi+1 -: 2];
            assign w_word[gi]       = w_sync[2*gi+1];
        end
    endgenerate

    // The current vector counts as one stable cycle; r_stab_cnt holds the cycles it was seen before.
    assign w_same = (w_sync == r_prev_sync);

    generate
        if (STABLE_CYC <= 1) begin : g_stab_trivial
            assign w_stable = 1'b1;
        end else begin : g_stab_cnt
            assign w_stable = w_same && (r_stab_cnt >= SCW'(STABLE_CYC - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_sync <= '0;
            r_stab_cnt  <= '0;
        end else begin
            r_prev_sync <= w_sync;
            if (!w_same) begin
                r_stab_cnt <= SCW'(1);
            end else if (r_stab_cnt < SCW'(STABLE_CYC)) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end
        end
    end

    assign w_acc_data    = w_stable && (&w_is_data);
    assign w_acc_null    = w_stable && (&w_is_null);
    assign w_acc_illegal = w_stable && (|w_is_illegal);

    assign w_to_inc = ((r_state == S_IDLE) && !(&w_is_null) && !w_acc_data) ||
                      ((r_state == S_WAIT_NULL) && !w_acc_null);
    assign w_to_hit = w_to_inc && (r_to_cnt == TOW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        ack           = 1'b0;
        word_valid    = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_acc_illegal) begin
                    w_state_next  = S_ERR;
                    w_set_illegal = 1'b1;
                end else if (w_acc_data) begin
                    w_state_next = S_CAPTURE;
                    w_capture    = 1'b1;
                end else if (w_to_hit) begin
                    w_state_next  = S_ERR;
                    w_set_timeout = 1'b1;
                end
            end
            S_CAPTURE: begin
                ack          = 1'b1;
                word_valid   = 1'b1;
                w_state_next = S_WAIT_NULL;
            end
            S_WAIT_NULL: begin
                ack = 1'b1;
                if (w_acc_null) begin
                    w_state_next = S_IDLE;
                end else if (w_acc_illegal) begin
                    w_state_next  = S_ERR;
                    w_set_illegal = 1'b1;
                end else if (w_to_hit) begin
                    w_state_next  = S_ERR;
                    w_set_timeout = 1'b1;
                end
            end
            S_ERR: begin
                if (clear_err && w_acc_null) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // phase_word and token_cnt update on entry to CAPTURE so they are valid with word_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_phase_word  <= '0;
            r_token_cnt   <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if ((w_state_next != r_state) || ((r_state == S_IDLE) && (&w_is_null))) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_capture) begin
                r_phase_word <= w_word;
                r_token_cnt  <= r_token_cnt + 1'b1;
            end

            if (w_set_illegal) begin
                r_err_illegal <= 1'b1;
            end else if (clear_err) begin
                r_err_illegal <= 1'b0;
            end

            if (w_set_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (clear_err) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    assign phase_word  = r_phase_word;
    assign token_cnt   = r_token_cnt;
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_phase_sync_ctrl.sv
// Bench for phase_sync_ctrl: table-driven tokens, scoreboarded word_valid outputs and hand-built corner sequences.
// token_cnt is narrowed to 8 bits so the counter wrap is reached in a few hundred tokens.
module tb_phase_sync_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       ph0, ph1, ph2;
    logic             clear_err;
    logic             ack;
    logic [2:0]       phase_word;
    logic             word_valid;
    logic             busy;
    logic             err_illegal;
    logic             err_timeout;
    logic [CNT_W-1:0] token_cnt;

    always #5 clk = ~clk;

    phase_sync_ctrl #(
        .SYNC_STAGES(2),
        .STABLE_CYC (2),
        .TIMEOUT    (255),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ph0        (ph0),
        .ph1        (ph1),
        .ph2        (ph2),
        .clear_err  (clear_err),
        .ack        (ack),
        .phase_word (phase_word),
        .word_valid (word_valid),
        .busy       (busy),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout),
        .token_cnt  (token_cnt)
    );

    typedef struct packed {
        logic [2:0]       word;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [1:0] p0;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [2:0] word;
    } vec_t;

    exp_t             sb_q[$];
    vec_t             tbl[8];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return ack;
            1:       return busy;
            2:       return err_timeout;
            default: return word_valid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int max_cyc, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            if (pick(sel) === val) hit = 1'b1;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic drive(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2);
        ph0 = p0;
        ph1 = p1;
        ph2 = p2;
    endtask

    task automatic expect_token(input logic [2:0] w);
        exp_t e;
        exp_cnt = exp_cnt + 1'b1;
        e.word  = w;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic run_token(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2,
                             input logic [2:0] w);
        @(negedge clk);
        expect_token(w);
        drive(p0, p1, p2);
        wait_for(0, 1'b1, 12, "ack_rise");
        drive(2'b00, 2'b00, 2'b00);
        wait_for(0, 1'b0, 12, "ack_fall");
        check("busy_after_token", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        clear_err = 1'b0;
        drive(2'b00, 2'b00, 2'b00);
        sb_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: every word_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && word_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("phase_word", phase_word, e.word);
                check("token_cnt", token_cnt, e.cnt);
                $display("token: word=%b cnt=%0d (exp word=%b cnt=%0d)", phase_word, token_cnt, e.word, e.cnt);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r0, r1, r2;
        logic [2:0] rw;

        tbl[0] = '{p0: 2'b01, p1: 2'b01, p2: 2'b01, word: 3'b000};
        tbl[1] = '{p0: 2'b10, p1: 2'b01, p2: 2'b01, word: 3'b001};
        tbl[2] = '{p0: 2'b01, p1: 2'b10, p2: 2'b01, word: 3'b010};
        tbl[3] = '{p0: 2'b10, p1: 2'b10, p2: 2'b01, word: 3'b011};
        tbl[4] = '{p0: 2'b01, p1: 2'b01, p2: 2'b10, word: 3'b100};
        tbl[5] = '{p0: 2'b10, p1: 2'b01, p2: 2'b10, word: 3'b101};
        tbl[6] = '{p0: 2'b01, p1: 2'b10, p2: 2'b10, word: 3'b110};
        tbl[7] = '{p0: 2'b10, p1: 2'b10, p2: 2'b10, word: 3'b111};

        rst       = 1'b1;
        clear_err = 1'b0;
        drive(2'b00, 2'b00, 2'b00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_phase_word", phase_word, 0);
        check("rst_busy", busy, 0);
        check("rst_err_illegal", err_illegal, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_token_cnt", token_cnt, 0);

        // Exact capture and release latency: four edges after the input change.
        expect_token(3'b010);
        drive(2'b01, 2'b10, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) check("ack_early", ack, 0);
        end
        check("lat_ack", ack, 1);
        check("lat_word_valid", word_valid, 1);
        check("lat_busy", busy, 1);
        check("lat_phase_word", phase_word, 3'b010);
        check("lat_token_cnt", token_cnt, 1);
        drive(2'b00, 2'b00, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) check("word_valid_one_cycle", word_valid, 0);
            if (k < 4) check("ack_held", ack, 1);
        end
        check("lat_ack_fall", ack, 0);
        check("lat_idle", busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_token(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].word);
        end

        // One-cycle ILLEGAL glitch on ph1 must be filtered out.
        @(negedge clk);
        drive(2'b01, 2'b11, 2'b10);
        @(negedge clk);
        ph1 = 2'b10;
        expect_token(3'b110);
        wait_for(0, 1'b1, 12, "glitch_ack_rise");
        check("glitch_no_err", err_illegal, 0);
        drive(2'b00, 2'b00, 2'b00);
        wait_for(0, 1'b0, 12, "glitch_ack_fall");

        // DATA-to-DATA change while waiting for NULL must not re-capture.
        @(negedge clk);
        expect_token(3'b000);
        drive(2'b01, 2'b01, 2'b01);
        wait_for(0, 1'b1, 12, "redata_ack_rise");
        ph0 = 2'b10;
        repeat (8) @(negedge clk);
        check("redata_ack_hold", ack, 1);
        check("redata_token_cnt", token_cnt, 32'(exp_cnt));
        drive(2'b00, 2'b00, 2'b00);
        wait_for(0, 1'b0, 12, "redata_ack_fall");

        // Held ILLEGAL enters ERR, which persists until clear_err with all-NULL.
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b11);
        repeat (4) @(negedge clk);
        check("illegal_flag", err_illegal, 1);
        check("illegal_ack", ack, 0);
        check("illegal_busy", busy, 1);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00);
        repeat (8) @(negedge clk);
        check("err_holds_busy", busy, 1);
        check("err_holds_flag", err_illegal, 1);
        clear_err = 1'b1;
        wait_for(1, 1'b0, 12, "err_exit");
        check("clear_illegal", err_illegal, 0);
        check("clear_timeout", err_timeout, 0);
        clear_err = 1'b0;

        // Error setting wins over a simultaneous clear_err.
        @(negedge clk);
        clear_err = 1'b1;
        drive(2'b10, 2'b10, 2'b11);
        repeat (4) @(negedge clk);
        check("set_wins", err_illegal, 1);
        @(negedge clk);
        check("clear_after_set", err_illegal, 0);
        drive(2'b00, 2'b00, 2'b00);
        wait_for(1, 1'b0, 12, "set_wins_exit");
        clear_err = 1'b0;

        // Partial mix never captures and times out after 255 counting cycles.
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b00);
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            if (k == 256) check("timeout_early", err_timeout, 0);
        end
        check("timeout_flag", err_timeout, 1);
        check("timeout_ack", ack, 0);
        check("timeout_busy", busy, 1);
        drive(2'b00, 2'b00, 2'b00);
        clear_err = 1'b1;
        wait_for(1, 1'b0, 12, "timeout_exit");
        check("timeout_cleared", err_timeout, 0);
        clear_err = 1'b0;

        // Reset in WAIT_NULL drops ack at once; a fresh token follows normally.
        @(negedge clk);
        expect_token(3'b100);
        drive(2'b01, 2'b01, 2'b10);
        wait_for(0, 1'b1, 12, "prerst_ack_rise");
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00);
        sb_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ack", ack, 0);
        check("midrst_token_cnt", token_cnt, 0);
        check("midrst_phase_word", phase_word, 0);
        check("midrst_word_valid", word_valid, 0);
        run_token(2'b10, 2'b01, 2'b10, 3'b101);

        // Counter wrap over 300 random tokens.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r0 = 2'($urandom_range(1, 2));
            r1 = 2'($urandom_range(1, 2));
            r2 = 2'($urandom_range(1, 2));
            rw = {r2 == 2'b10, r1 == 2'b10, r0 == 2'b10};
            run_token(r0, r1, r2, rw);
        end
        check("token_cnt_wrap", token_cnt, 44);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phase_sync_ctrl.md
Name: phase_sync_ctrl

Overview:
- Synchronous consumer for the dual-rail phase tokens PH0/PH1/PH2 produced by the asynchronous phase ring.
- Synchronizes the three dual-rail pairs into the clk domain and detects token completion.
- Emits one decoded 3-bit phase word per token and drives the four-phase return acknowledge back into the ring's ack input.
- Filters glitches and flags protocol errors and stalls.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each rail synchronizer (minimum 2).
- STABLE_CYC, 2, consecutive identical synchronized samples required before a condition is accepted (minimum 1).
- TIMEOUT, 255, cycles allowed for an incomplete token or an incomplete return-to-null before err_timeout.
- CNT_W, 16, width of token_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ph0  in  2  dual-rail phase 0: 00 NULL, 01 DATA0, 10 DATA1, 11 ILLEGAL. Asynchronous to clk.
- ph1  in  2  dual-rail phase 1, same encoding.
- ph2  in  2  dual-rail phase 2, same encoding.
- clear_err  in  1  clears sticky errors; releases ERR.
- ack  out  1  four-phase acknowledge to the phase ring.
- phase_word  out  3  bit i = value of phase i (DATA1=1); held until next token.
- word_valid  out  1  one-cycle pulse when phase_word updates.
- busy  out  1  high in any state other than IDLE.
- err_illegal  out  1  sticky: ILLEGAL code accepted on some phase.
- err_timeout  out  1  sticky: TIMEOUT expired.
- token_cnt  out  CNT_W  completed tokens, wraps modulo 2^CNT_W.

Behaviour:
- Reset (sync, rst=1 at edge) clears all synchronizer flops, counters and flags; FSM goes to IDLE.
  - Outputs after reset: ack=0, word_valid=0, phase_word=000, busy=0, err_*=0, token_cnt=0.
  - Reset mid-handshake drops ack immediately; no word_valid is issued.
- Each of the 6 rails passes through its own SYNC_STAGES chain. Decode acts on synchronized values only.
- A stability counter counts consecutive cycles in which the synchronized 6-bit vector is unchanged. It restarts on any change.
- A condition is "accepted" when it holds and the vector has been stable for STABLE_CYC cycles.
- FSM states:
  - IDLE (ack=0):
    - Accepted ILLEGAL on any phase -> ERR; set err_illegal.
    - Accepted all-three-DATA -> CAPTURE.
  - CAPTURE (1 cycle):
    - Register phase_word, pulse word_valid, increment token_cnt, set ack=1.
    - Go to WAIT_NULL.
  - WAIT_NULL (ack=1):
    - Accepted all-three-NULL -> IDLE; ack=0 on that edge.
    - Accepted ILLEGAL -> ERR.
  - ERR (ack=0):
    - Stays until clear_err=1 and all-NULL is accepted -> IDLE.
    - clear_err clears err_illegal and err_timeout in any state. If clear_err coincides with an error-setting event, the set wins.
- Latency: ack and word_valid rise on edge SYNC_STAGES+STABLE_CYC, counted from the first edge that samples the final input change (4 for defaults). The ack fall has the same latency after the NULL is complete.
- Timeout counter:
  - Increments in IDLE while any phase is non-NULL and all-DATA has not been accepted.
  - Increments in WAIT_NULL while all-NULL has not been accepted.
  - Clears on any state change and when all phases are NULL in IDLE.
  - On reaching TIMEOUT: set err_timeout, go to ERR.
- Partial mixes (e.g. two DATA, one NULL) never capture.
- A DATA value changing to a different DATA value while in WAIT_NULL does not re-capture.

Test Plan:
- Reset, then ph0=01, ph1=10, ph2=01 -> ack=1 and word_valid pulse at edge 4; phase_word=010; token_cnt=1; busy=1.
- From the previous state, set all ph=00 -> ack=0 at edge 4 after the change; state IDLE. Repeat 70000 tokens -> token_cnt wraps to 70000 mod 65536 = 4464.
- ph1=11 for 1 cycle, then 10 (other phases DATA) -> no err_illegal; capture with phase_word bit1=1.
- ph2=11 held 5 cycles -> err_illegal=1, ack=0, state ERR. clear_err=1 with all NULL -> flags 0, IDLE.
- ph0=01, ph1=01, ph2=00 held -> err_timeout=1 after 255 cycles, no word_valid, ack=0.
- rst=1 for 1 edge during WAIT_NULL -> next cycle ack=0, token_cnt=0, phase_word=000; a complete new token is captured normally afterwards.
